char_source_arbiter: RTL and testbench
======================================

// Module: char_source_arbiter
// PURPOSE
//  Shares the character feeder between two byte sources: A = UART RX, B = PS/2 keyboard decoder.
//  Each source uses a valid/ready handshake. Accepted bytes are queued in a small FIFO.
//  The FIFO is drained to the feeder as single-cycle write strobes, spaced at least PACE cycles apart.
//  The clear code (0xFF) flushes pending text so that a clear is never applied behind stale characters.
// PARAMETERS
//  DEPTH     8      FIFO entries; power of 2, >= 2
//  PACE      2      min cycles between out_we rising edges; >= 1 (1 = back-to-back)
//  CLR_CODE  8'hFF  screen-clear byte; triggers a flush
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   reset, asynchronous assert, active-low
//  a_data      in   8   source A byte
//  a_valid     in   1   A offers a_data
//  a_ready     out  1   A byte accepted at this edge when a_valid & a_ready
//  b_data      in   8   source B byte
//  b_valid     in   1   B offers b_data
//  b_ready     out  1   as a_ready, for B
//  out_data    out  8   byte to feeder idi; registered; holds last value
//  out_we      out  1   one-cycle write strobe to feeder we
//  busy        out  1   FIFO non-empty or issue FSM not IDLE
//  fifo_count  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
// BEHAVIOUR
//  Reset (rst_n=0, takes effect immediately):
//   - out_we=0, out_data=0, fifo_count=0, busy=0.
//   - FSM=IDLE; round-robin pointer favours A.
//   - Reset mid-burst discards all queued bytes.
//  Grant (combinational):
//   - Only one valid source: that source is granted.
//   - Both valid: the source not served by the last accepted transfer is granted.
//   - The pointer updates only on an accepted transfer.
//  Ready:
//   - x_ready = granted_x & (!full | x_data==CLR_CODE).
//   - The non-granted ready is 0.
//   - Never more than one accept per cycle.
//   - Data and valid must hold until accepted.
//  Accept, normal byte: written at FIFO tail; fifo_count +1 after the edge.
//  Accept, CLR_CODE (also accepted when full):
//   - After the edge, the FIFO holds only {CLR_CODE}; fifo_count=1.
//   - A pop at the same edge still issues its old head byte.
//   - Flush wins over any other write.
//  Issue FSM:
//   - IDLE: when !empty, pop at edge; out_data<=head, out_we<=1; go to ISSUE.
//   - ISSUE: out_we<=0. If PACE==1, return to IDLE (a pop may occur at this same edge, giving back-to-back strobes). Else go to GAP with gap counter = PACE-2.
//   - GAP: decrement; at 0 go to IDLE.
//   - Net effect: strobes are exactly PACE cycles apart while data is queued.
//  Latency: byte accepted at edge k into an empty FIFO, FSM in IDLE -> out_we=1 and out_data valid from edge k+1 to edge k+2.
//  Simultaneous push+pop: fifo_count unchanged; full stays full, so a normal byte is refused that cycle.
//  Pointers wrap modulo DEPTH. Full = count==DEPTH; empty = count==0.
//  Order preserved; no byte dropped except by flush or reset.
// STRUCTURE
//  Shared package char_pkg:
//   - CLR_CODE constant; issue FSM state enum (IDLE, ISSUE, GAP).
//   - Screen geometry constants (20 columns, 7 rows, 140 cells), shared with the feeder.
//  One sub-module char_fifo: DEPTH x 8 synchronous FIFO with push, pop, flush_load (load single byte), count.
//  Arbiter, ready logic and issue FSM live in this module.
// TESTING
//  1 Hold rst_n=0 -> out_we=0, out_data=0, fifo_count=0, busy=0; a_ready=1 on a_valid=1 with b_valid=0.
//  2 A sends 0x41 at edge k, FIFO empty -> out_we=1, out_data=0x41 for one cycle from edge k+1; busy drops once the FSM returns to IDLE.
//  3 A streams 0x31,0x32.. and B streams 0x61,0x62.., both always valid -> accept order A,B,A,B; out stream 0x31,0x61,0x32,0x62; strobes 2 cycles apart.
//  4 PACE=4, B streams 12 bytes every cycle -> fifo_count reaches 8, b_ready=0 while full; all 12 bytes appear in order.
//  5 FIFO full (8), A presents 0xFF -> a_ready=1; after the edge fifo_count=1; next strobe carries 0xFF; the queued 8 bytes never appear.
//  6 rst_n pulsed low between edges mid-burst -> out_we=0 immediately, fifo_count=0; after release, the first strobe carries the first newly accepted byte.

Source files
------------

// File: rtl/char_pkg.sv
// rtl/char_pkg.sv - shared constants and issue FSM states for the character path
package char_pkg;

  localparam logic [7:0] CHAR_CLR_CODE = 8'hFF;

  // Screen geometry shared with the feeder
  localparam int SCREEN_COLS  = 20;
  localparam int SCREEN_ROWS  = 7;
  localparam int SCREEN_CELLS = SCREEN_COLS * SCREEN_ROWS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } issue_state_t;

endpackage

// File: rtl/char_fifo.sv
// rtl/char_fifo.sv - DEPTH x 8 synchronous FIFO with flush-and-load of a single byte
module char_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  input  logic                   flush_load,
  input  logic [7:0]             flush_data,
  output logic [7:0]             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (PW + 1)'(DEPTH));

  // Flush discards everything and leaves exactly the loaded byte at slot 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_load) begin
      rd_ptr <= '0;
      wr_ptr <= PW'(1);
      count  <= (PW + 1)'(1);
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (flush_load)  mem[0]      <= flush_data;
    else if (push)   mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/char_source_arbiter.sv
// rtl/char_source_arbiter.sv - round-robin merge of UART and PS/2 bytes into a paced feeder strobe
module char_source_arbiter
  import char_pkg::*;
#(
  parameter int         DEPTH    = 8,
  parameter int         PACE     = 2,
  parameter logic [7:0] CLR_CODE = CHAR_CLR_CODE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             a_data,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [7:0]             b_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  output logic [7:0]             out_data,
  output logic                   out_we,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int GW = (PACE > 2) ? $clog2(PACE - 1) : 1;

  issue_state_t  state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          last_b;
  logic          grant_a, grant_b;
  logic          acc_a, acc_b, acc_clr;
  logic [7:0]    acc_data;
  logic          slot_free, pop;
  logic [7:0]    head;
  logic          empty, full;

  // last_b resets high so that A wins the first contested cycle
  assign grant_a = a_valid & (~b_valid | last_b);
  assign grant_b = b_valid & (~a_valid | ~last_b);
  assign a_ready = grant_a & (~full | (a_data == CLR_CODE));
  assign b_ready = grant_b & (~full | (b_data == CLR_CODE));

  assign acc_a    = a_valid & a_ready;
  assign acc_b    = b_valid & b_ready;
  assign acc_data = acc_a ? a_data : b_data;
  assign acc_clr  = (acc_a | acc_b) & (acc_data == CLR_CODE);

  char_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       ((acc_a | acc_b) & ~acc_clr),
    .push_data  (acc_data),
    .pop        (pop),
    .flush_load (acc_clr),
    .flush_data (CLR_CODE),
    .head       (head),
    .count      (fifo_count),
    .empty      (empty),
    .full       (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              last_b <= 1'b1;
    else if (acc_a | acc_b)  last_b <= acc_b;
  end

  // A pop can happen on the very edge that ends the pacing window
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    slot_free = 1'b0;
    case (state_q)
      IDLE:  slot_free = 1'b1;
      ISSUE: begin
        if (PACE == 1) begin
          slot_free = 1'b1;
        end else begin
          state_d = GAP;
          gap_d   = GW'(PACE - 2);
        end
      end
      GAP: begin
        if (gap_q == '0) slot_free = 1'b1;
        else             gap_d     = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    pop = slot_free & ~empty;
    if (slot_free) state_d = pop ? ISSUE : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      out_we   <= 1'b0;
      out_data <= 8'h00;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      out_we  <= pop;
      if (pop) out_data <= head;
    end
  end

  assign busy = ~empty | (state_q != IDLE);

endmodule

// File: tb/tb_char_source_arbiter.sv
// tb/tb_char_source_arbiter.sv - randomized and directed checks of char_source_arbiter
module tb_char_source_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] a_data0, b_data0, a_data1, b_data1, out_data0, out_data1;
  logic       a_valid0, b_valid0, a_valid1, b_valid1;
  logic       a_ready0, b_ready0, a_ready1, b_ready1;
  logic       out_we0, out_we1, busy0, busy1;
  logic [3:0] fifo_count0, fifo_count1;

  char_source_arbiter #(.DEPTH(8), .PACE(2), .CLR_CODE(8'hFF)) u0 (
    .clk(clk), .rst_n(rst_n), .a_data(a_data0), .a_valid(a_valid0), .a_ready(a_ready0),
    .b_data(b_data0), .b_valid(b_valid0), .b_ready(b_ready0), .out_data(out_data0),
    .out_we(out_we0), .busy(busy0), .fifo_count(fifo_count0));

  char_source_arbiter #(.DEPTH(8), .PACE(4), .CLR_CODE(8'hFF)) u1 (
    .clk(clk), .rst_n(rst_n), .a_data(a_data1), .a_valid(a_valid1), .a_ready(a_ready1),
    .b_data(b_data1), .b_valid(b_valid1), .b_ready(b_ready1), .out_data(out_data1),
    .out_we(out_we1), .busy(busy1), .fifo_count(fifo_count1));

  int total = 0;
  int bad   = 0;
  int sel;
  int pace;

  // Reference model: a byte queue plus the time of the last strobe
  logic [7:0] mq[$];
  bit         m_last_b;
  int         m_edge, m_last_strobe;
  bit         e_ar, e_br, e_we, e_busy;
  logic [7:0] e_data;
  int         e_cnt;

  logic       o_ar, o_br, o_we, o_busy;
  logic [7:0] o_data;
  logic [3:0] o_cnt;

  logic [7:0] sa[$], sb[$];
  bit         a_hold, b_hold;
  logic [7:0] out_log[$], exp_log[$];
  bit         acc_src[$];
  int         obs_t[$];

  task automatic idle_inputs();
    a_valid0 = 0; b_valid0 = 0; a_valid1 = 0; b_valid1 = 0;
    a_data0 = 0; b_data0 = 0; a_data1 = 0; b_data1 = 0;
  endtask

  task automatic model_reset();
    mq.delete(); sa.delete(); sb.delete();
    out_log.delete(); exp_log.delete(); acc_src.delete(); obs_t.delete();
    m_last_b = 1; m_edge = 0; m_last_strobe = -100;
    a_hold = 0; b_hold = 0;
    e_we = 0; e_data = 0; e_cnt = 0; e_busy = 0;
  endtask

  task automatic do_reset(input int s);
    sel = s;
    pace = (s == 1) ? 4 : 2;
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic run_cycle(input int gap_pct);
    bit av, bv, full, pop;
    logic [7:0] ad, bd, acc_d;
    @(negedge clk);
    av = (sa.size() > 0) && (a_hold || ($urandom_range(99) >= gap_pct));
    bv = (sb.size() > 0) && (b_hold || ($urandom_range(99) >= gap_pct));
    ad = av ? sa[0] : 8'($urandom);
    bd = bv ? sb[0] : 8'($urandom);
    a_hold = av; b_hold = bv;
    if (sel == 1) begin
      a_valid1 = av; a_data1 = ad; b_valid1 = bv; b_data1 = bd;
    end else begin
      a_valid0 = av; a_data0 = ad; b_valid0 = bv; b_data0 = bd;
    end
    // Contested cycles go to whichever source was not served last
    full = (mq.size() >= 8);
    e_ar = av && (!bv || m_last_b) && (!full || ad == 8'hFF);
    e_br = bv && (!av || !m_last_b) && (!full || bd == 8'hFF);
    #1;
    o_ar = (sel == 1) ? a_ready1 : a_ready0;
    o_br = (sel == 1) ? b_ready1 : b_ready0;
    @(posedge clk);
    m_edge++;
    pop = (mq.size() > 0) && (m_edge - m_last_strobe >= pace);
    e_we = pop;
    if (pop) begin
      e_data = mq.pop_front();
      m_last_strobe = m_edge;
      exp_log.push_back(e_data);
    end
    if (e_ar || e_br) begin
      acc_d = e_ar ? ad : bd;
      acc_src.push_back(e_br);
      if (acc_d == 8'hFF) begin
        mq.delete();
        mq.push_back(8'hFF);
      end else begin
        mq.push_back(acc_d);
      end
      m_last_b = e_br;
      if (e_ar) begin void'(sa.pop_front()); a_hold = 0; end
      else      begin void'(sb.pop_front()); b_hold = 0; end
    end
    e_cnt  = mq.size();
    e_busy = (mq.size() > 0) || (m_edge - m_last_strobe < pace);
    #1;
    o_we   = (sel == 1) ? out_we1 : out_we0;
    o_data = (sel == 1) ? out_data1 : out_data0;
    o_cnt  = (sel == 1) ? fifo_count1 : fifo_count0;
    o_busy = (sel == 1) ? busy1 : busy0;
    if (o_we === 1'b1) begin
      out_log.push_back(o_data);
      obs_t.push_back(m_edge);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1;
    #2 rst_n = 0;
    a_valid0 = 1; a_data0 = 8'h41;
    #1;
    total++; if (out_we0 !== 1'b0) begin bad++; $display("FAIL reset out_we got %b exp 0", out_we0); end
    total++; if (out_data0 !== 8'h00) begin bad++; $display("FAIL reset out_data got %h exp 00", out_data0); end
    total++; if (fifo_count0 !== 4'd0) begin bad++; $display("FAIL reset fifo_count got %0d exp 0", fifo_count0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset busy got %b exp 0", busy0); end
    total++; if (a_ready0 !== 1'b1) begin bad++; $display("FAIL reset a_ready got %b exp 1", a_ready0); end
    total++; if (b_ready0 !== 1'b0) begin bad++; $display("FAIL reset b_ready got %b exp 0", b_ready0); end
  endtask

  task automatic test_single();
    do_reset(0);
    sa.push_back(8'h41);
    run_cycle(0);
    total++; if (o_ar !== 1'b1) begin bad++; $display("FAIL single a_ready got %b exp 1", o_ar); end
    total++; if (o_cnt !== 4'd1 || o_we !== 1'b0) begin bad++; $display("FAIL single accept cnt=%0d we=%b exp 1,0", o_cnt, o_we); end
    run_cycle(0);
    total++; if (o_we !== 1'b1 || o_data !== 8'h41) begin bad++; $display("FAIL single strobe we=%b data=%h exp 1,41", o_we, o_data); end
    run_cycle(0);
    total++; if (o_we !== 1'b0 || o_busy !== 1'b1) begin bad++; $display("FAIL single gap we=%b busy=%b exp 0,1", o_we, o_busy); end
    run_cycle(0);
    total++; if (o_busy !== 1'b0 || o_cnt !== 4'd0) begin bad++; $display("FAIL single idle busy=%b cnt=%0d exp 0,0", o_busy, o_cnt); end
  endtask

  task automatic test_alternate();
    logic [7:0] want[4];
    want[0] = 8'h31; want[1] = 8'h61; want[2] = 8'h32; want[3] = 8'h62;
    do_reset(0);
    for (int i = 0; i < 8; i++) begin
      sa.push_back(8'h31 + 8'(i));
      sb.push_back(8'h61 + 8'(i));
    end
    for (int c = 0; c < 45; c++) begin
      run_cycle(0);
      total++; if (o_ar !== e_ar || o_br !== e_br) begin bad++; $display("FAIL alt ready c=%0d got %b%b exp %b%b", c, o_ar, o_br, e_ar, e_br); end
      total++; if (o_we !== e_we || (e_we && o_data !== e_data)) begin bad++; $display("FAIL alt out c=%0d got %b/%h exp %b/%h", c, o_we, o_data, e_we, e_data); end
      total++; if (o_cnt !== 4'(e_cnt) || o_busy !== e_busy) begin bad++; $display("FAIL alt cnt c=%0d got %0d/%b exp %0d/%b", c, o_cnt, o_busy, e_cnt, e_busy); end
    end
    total++;
    if (acc_src.size() < 4 || acc_src[0] !== 1'b0 || acc_src[1] !== 1'b1 || acc_src[2] !== 1'b0 || acc_src[3] !== 1'b1) begin
      bad++; $display("FAIL alt accept order got %0d entries, exp A,B,A,B", acc_src.size());
    end
    total++; if (out_log.size() != 16) begin bad++; $display("FAIL alt out count got %0d exp 16", out_log.size()); end
    for (int i = 0; i < 4 && i < out_log.size(); i++) begin
      total++; if (out_log[i] !== want[i]) begin bad++; $display("FAIL alt out[%0d] got %h exp %h", i, out_log[i], want[i]); end
    end
    for (int i = 1; i < 7 && i < obs_t.size(); i++) begin
      total++; if (obs_t[i] - obs_t[i-1] != 2) begin bad++; $display("FAIL alt spacing[%0d] got %0d exp 2", i, obs_t[i] - obs_t[i-1]); end
    end
  endtask

  task automatic test_fill();
    int max_cnt = 0;
    logic [3:0] prev_cnt = 0;
    do_reset(1);
    for (int i = 0; i < 12; i++) sb.push_back(8'h80 + 8'(i));
    for (int c = 0; c < 70; c++) begin
      run_cycle(0);
      total++; if (prev_cnt == 4'd8 && o_br !== 1'b0) begin bad++; $display("FAIL fill b_ready while full c=%0d got %b exp 0", c, o_br); end
      total++; if (o_br !== e_br) begin bad++; $display("FAIL fill b_ready c=%0d got %b exp %b", c, o_br, e_br); end
      total++; if (o_cnt !== 4'(e_cnt)) begin bad++; $display("FAIL fill cnt c=%0d got %0d exp %0d", c, o_cnt, e_cnt); end
      if (int'(o_cnt) > max_cnt) max_cnt = int'(o_cnt);
      prev_cnt = o_cnt;
    end
    total++; if (max_cnt != 8) begin bad++; $display("FAIL fill max count got %0d exp 8", max_cnt); end
    total++; if (out_log.size() != 12) begin bad++; $display("FAIL fill out count got %0d exp 12", out_log.size()); end
    for (int i = 0; i < out_log.size() && i < 12; i++) begin
      total++; if (out_log[i] !== 8'h80 + 8'(i)) begin bad++; $display("FAIL fill order[%0d] got %h exp %h", i, out_log[i], 8'h80 + 8'(i)); end
    end
  endtask

  task automatic test_clear();
    int phase = 0;
    int n0 = 0;
    int leaks = 0;
    logic [7:0] snap[$];
    do_reset(1);
    for (int i = 0; i < 20; i++) sb.push_back(8'hA0 + 8'(i));
    for (int c = 0; c < 100; c++) begin
      run_cycle(0);
      total++; if (o_we !== e_we || (e_we && o_data !== e_data) || o_cnt !== 4'(e_cnt)) begin
        bad++; $display("FAIL clr c=%0d got we=%b d=%h n=%0d exp %b/%h/%0d", c, o_we, o_data, o_cnt, e_we, e_data, e_cnt);
      end
      if (phase == 1) begin
        total++; if (o_ar !== 1'b1) begin bad++; $display("FAIL clr a_ready when full got %b exp 1", o_ar); end
        total++; if (o_cnt !== 4'd1) begin bad++; $display("FAIL clr count after flush got %0d exp 1", o_cnt); end
        n0 = out_log.size();
        phase = 2;
      end
      if (phase == 0 && e_cnt == 8) begin
        snap = mq;
        sa.push_back(8'hFF);
        phase = 1;
      end
    end
    total++; if (phase != 2) begin bad++; $display("FAIL clr never reached full got phase %0d exp 2", phase); end
    total++; if (out_log.size() <= n0 || out_log[n0] !== 8'hFF) begin bad++; $display("FAIL clr first strobe after flush not ff, n=%0d", out_log.size() - n0); end
    for (int i = n0; i < out_log.size(); i++)
      for (int j = 0; j < snap.size(); j++)
        if (out_log[i] === snap[j]) leaks++;
    total++; if (leaks != 0) begin bad++; $display("FAIL clr flushed bytes reappeared got %0d exp 0", leaks); end
  endtask

  task automatic test_reset_mid();
    bit got = 0;
    do_reset(0);
    for (int i = 0; i < 8; i++) sa.push_back(8'hC0 + 8'(i));
    repeat (6) run_cycle(0);
    @(negedge clk);
    #2;
    idle_inputs();
    rst_n = 0;
    #1;
    total++; if (out_we0 !== 1'b0) begin bad++; $display("FAIL rmid out_we got %b exp 0", out_we0); end
    total++; if (fifo_count0 !== 4'd0 || busy0 !== 1'b0) begin bad++; $display("FAIL rmid count/busy got %0d/%b exp 0/0", fifo_count0, busy0); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    sa.push_back(8'h5A);
    for (int c = 0; c < 8 && !got; c++) begin
      run_cycle(0);
      if (o_we === 1'b1) begin
        got = 1;
        total++; if (o_data !== 8'h5A) begin bad++; $display("FAIL rmid first strobe got %h exp 5a", o_data); end
      end
    end
    total++; if (!got) begin bad++; $display("FAIL rmid no strobe after reset got 0 exp 1"); end
  endtask

  task automatic test_random();
    do_reset(0);
    for (int i = 0; i < 40; i++) begin
      sa.push_back(($urandom_range(9) == 0) ? 8'hFF : 8'($urandom_range(254)));
      sb.push_back(($urandom_range(9) == 0) ? 8'hFF : 8'($urandom_range(254)));
    end
    for (int c = 0; c < 300; c++) begin
      run_cycle(30);
      total++; if (o_ar !== e_ar || o_br !== e_br) begin bad++; $display("FAIL rnd ready c=%0d got %b%b exp %b%b", c, o_ar, o_br, e_ar, e_br); end
      total++; if (o_we !== e_we || (e_we && o_data !== e_data)) begin bad++; $display("FAIL rnd out c=%0d got %b/%h exp %b/%h", c, o_we, o_data, e_we, e_data); end
      total++; if (o_cnt !== 4'(e_cnt) || o_busy !== e_busy) begin bad++; $display("FAIL rnd cnt c=%0d got %0d/%b exp %0d/%b", c, o_cnt, o_busy, e_cnt, e_busy); end
    end
    total++; if (sa.size() != 0 || sb.size() != 0 || out_log.size() != exp_log.size()) begin
      bad++; $display("FAIL rnd drain left %0d/%0d out %0d exp %0d", sa.size(), sb.size(), out_log.size(), exp_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_fill();
    test_clear();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
